// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum stage is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        DONE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four bytes, first byte most significant, into one 32-bit word.
// Index and shift register are cleared on reset or at load start.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] sh_q, sh_d;

    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        if (clear_i) begin
            idx_d = '0;
            sh_d  = '0;
        end else if (accept_i) begin
            idx_d = idx_q + 2'd1;
            sh_d  = {sh_q[23:0], data_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

    assign word_o      = sh_q;
    assign word_full_o = accept_i && !clear_i &&
                         (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing big-endian words to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_BYTES = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [33:0] DEPTH34 = 34'(DEPTH_BYTES);

    state_e      state_q, state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [31:0] nw_q, nw_d;
    logic [31:0] laddr_q, laddr_d;
    logic [31:0] lwdata_q, lwdata_d;
    logic        err_q, err_d;
    logic        pk_clear, pk_accept, pk_full;
    logic [31:0] pk_word;
    logic        ovf;
    logic        last;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum_q, sum_d, sum_chk;
    assign sum_chk = sum_q + byte_data;
`endif

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .accept_i    (pk_accept),
        .data_i      (byte_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    // 34-bit product so huge word counts cannot wrap past the check
    assign ovf  = ({2'b00, num_words} << 2) > DEPTH34;
    assign last = (wcnt_q + 32'd1) == nw_q;

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        wcnt_d     = wcnt_q;
        nw_d       = nw_q;
        laddr_d    = laddr_q;
        lwdata_d   = lwdata_q;
        err_d      = err_q;
        pk_clear   = 1'b0;
        pk_accept  = 1'b0;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    if (num_words == 32'd0) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else if (ovf) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = COLLECT;
                        waddr_d  = '0;
                        wcnt_d   = '0;
                        nw_d     = num_words;
                        err_d    = 1'b0;
                        pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d    = '0;
`endif
                    end
                end
            end
            COLLECT: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                pk_accept  = byte_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (byte_valid) sum_d = sum_chk;
`endif
                if (pk_full) state_d = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                laddr_d  = waddr_q;
                lwdata_d = pk_word;
                waddr_d  = waddr_q + 32'(BYTES_PER_WORD);
                wcnt_d   = wcnt_q + 32'd1;
                if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    err_d   = (sum_chk != '0);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            wcnt_q   <= '0;
            nw_q     <= '0;
            laddr_q  <= '0;
            lwdata_q <= '0;
            err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            wcnt_q   <= wcnt_d;
            nw_q     <= nw_d;
            laddr_q  <= laddr_d;
            lwdata_q <= lwdata_d;
            err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign mem_addr  = mem_we ? waddr_q : laddr_q;
    assign mem_wdata = mem_we ? pk_word : lwdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of loads plus reset sequences.
// Checksum expectations follow IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;

    imem_loader #(.DEPTH_BYTES(160)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] nw;
        logic [63:0] by;
        bit          pat;
        bit          gap;
        bit          ovf;
        logic [7:0]  ck;
        bit          ckerr;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_bad = 0;
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    vec_t        vecs[9];

    always @(negedge clk) begin
        if (mem_we) begin
            wq_a.push_back(mem_addr);
            wq_d.push_back(mem_wdata);
            if (byte_ready) rdy_bad++;
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] gb(input vec_t v, input int i);
        if (v.pat) return i[7:0];
        return v.by[63-8*i -: 8];
    endfunction

    task automatic send(input logic [7:0] b, input bit gap,
                        input string nm);
        bit ok;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, " ready_timeout"}, 32'(ok), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit   ok;
        int   nexp;
        bit   eerr;
        logic [31:0] ew;
        wq_a.delete();
        wq_d.delete();
        rdy_bad = 0;
        @(negedge clk);
        start     = 1'b1;
        num_words = v.nw;
        @(negedge clk);
        start = 1'b0;
        if (v.nw == 0 || v.ovf) begin
            chk({v.nm, " done"}, 32'(done), 32'd1);
            chk({v.nm, " err"}, 32'(err), 32'(v.ovf));
            chk({v.nm, " ready"}, 32'(byte_ready), 32'd0);
            chk({v.nm, " busy"}, 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            chk({v.nm, " nwrites"}, 32'(wq_a.size()), 32'd0);
            return;
        end
        chk({v.nm, " busy1"}, 32'(busy), 32'd1);
        chk({v.nm, " ready1"}, 32'(byte_ready), 32'd1);
        chk({v.nm, " done_clr"}, 32'(done), 32'd0);
        nexp = int'(v.nw);
        for (int i = 0; i < nexp * 4; i++) begin
            send(gb(v, i), v.gap, v.nm);
            if (i % 4 == 3 && i < 8) begin
                chk({v.nm, " we_k1"}, 32'(mem_we), 32'd1);
                chk({v.nm, " rdy_k1"}, 32'(byte_ready), 32'd0);
            end
        end
        eerr = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(v.ck, v.gap, v.nm);
        eerr = v.ckerr;
`endif
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({v.nm, " done"}, 32'(ok), 32'd1);
        chk({v.nm, " busy0"}, 32'(busy), 32'd0);
        chk({v.nm, " err"}, 32'(err), 32'(eerr));
        chk({v.nm, " nwrites"}, 32'(wq_a.size()), 32'(nexp));
        chk({v.nm, " rdy_in_wr"}, 32'(rdy_bad), 32'd0);
        for (int w = 0; w < nexp && w < wq_a.size(); w++) begin
            ew = {gb(v, 4*w), gb(v, 4*w+1),
                  gb(v, 4*w+2), gb(v, 4*w+3)};
            chk({v.nm, " addr"}, wq_a[w], 32'(4*w));
            chk({v.nm, " data"}, wq_d[w], ew);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " ready"}, 32'(byte_ready), 32'd0);
        chk({nm, " we"}, 32'(mem_we), 32'd0);
        chk({nm, " addr"}, mem_addr, 32'd0);
        chk({nm, " wdata"}, mem_wdata, 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"basic", 32'd2, 64'h8C010004_20020005,
                    0, 0, 0, 8'h48, 0};
        vecs[1] = '{"gaps", 32'd2, 64'h8C010004_20020005,
                    0, 1, 0, 8'h48, 0};
        vecs[2] = '{"ovf41", 32'd41, 64'h0, 0, 0, 1, 8'h00, 0};
        vecs[3] = '{"zero", 32'd0, 64'h0, 0, 0, 0, 8'h00, 0};
        vecs[4] = '{"ck_ok", 32'd1, 64'h01020304_00000000,
                    0, 0, 0, 8'hF6, 0};
        vecs[5] = '{"ck_bad", 32'd1, 64'h01020304_00000000,
                    0, 0, 0, 8'hF5, 1};
        vecs[6] = '{"full40", 32'd40, 64'h0, 1, 0, 0, 8'h50, 0};
        vecs[7] = '{"ovf_wrap", 32'h4000_0000, 64'h0,
                    0, 0, 1, 8'h00, 0};
        vecs[8] = '{"ovf_max", 32'hFFFF_FFFF, 64'h0,
                    0, 1, 1, 8'h00, 0};

        @(negedge clk);
        chk_reset_vals("rst0");
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("idle");

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        @(negedge clk);
        start     = 1'b1;
        num_words = 32'd2;
        @(negedge clk);
        start = 1'b0;
        send(8'hAA, 0, "midrst");
        send(8'hBB, 0, "midrst");
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        run_vec('{"fresh", 32'd1, 64'h11223344_00000000,
                  0, 0, 0, 8'h56, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
